// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage of the multicycle computer. It holds the program counter and
// drives the read side of instruction_memory. It latches each returned word
// into the instruction register for the control unit and decoder.
//
// A fetch is started by a one-cycle fetch_request. It takes three cycles:
//   ISSUE : read strobe to memory
//   WAIT  : memory output valid
//   DONE  : instruction_valid pulse
// PC loads (branch/jump) are accepted at any time. A load that arrives while
// a fetch is in flight is held as pending and applied when that fetch
// completes. When several loads arrive during one fetch, the last one wins.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   fetch_request       start a fetch (sampled in IDLE or DONE only)
//   pc_load             load pc_load_value into the PC
//   pc_load_value       branch/jump target
//   imem_read_data      instruction_memory.read_data
//   imem_read_enable    instruction_memory.read_enable (high in ISSUE)
//   imem_address        instruction_memory.address (always the PC)
//   instruction         instruction register
//   instruction_address address the current instruction was fetched from
//   program_counter     next address to fetch
//   instruction_valid   one-cycle pulse when instruction is updated
//   busy                high in any state other than IDLE
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                    ADDR_WIDTH   = 14,
  parameter int                    INSTR_WIDTH  = 27,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 14'h2000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_request,
  input  logic                   pc_load,
  input  logic [ADDR_WIDTH-1:0]  pc_load_value,
  input  logic [INSTR_WIDTH-1:0] imem_read_data,
  output logic                   imem_read_enable,
  output logic [ADDR_WIDTH-1:0]  imem_address,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instruction_address,
  output logic [ADDR_WIDTH-1:0]  program_counter,
  output logic                   instruction_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]    pc_r, pc_next_s;
  logic                     pending_valid_r, pending_valid_next_s;
  logic [ADDR_WIDTH-1:0]    pending_value_r, pending_value_next_s;
  logic [INSTR_WIDTH-1:0]   instruction_r, instruction_next_s;
  logic [ADDR_WIDTH-1:0]    instr_addr_r, instr_addr_next_s;
  logic                     read_enable_r, valid_r, busy_r;

  // Next-state, PC, pending-load and capture logic.
  always_comb begin
    state_next_s         = state_r;
    pc_next_s            = pc_r;
    pending_valid_next_s = pending_valid_r;
    pending_value_next_s = pending_value_r;
    instruction_next_s   = instruction_r;
    instr_addr_next_s    = instr_addr_r;

    case (state_r)
      IDLE, DONE: begin
        // The PC updates on this edge, so a simultaneous request issues at
        // the loaded address.
        if (pc_load) begin
          pc_next_s = pc_load_value;
        end else begin
          pc_next_s = pc_r;
        end
        if (fetch_request) begin
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        // The PC must stay put while memory is being addressed, so the load
        // is deferred.
        if (pc_load) begin
          pending_valid_next_s = 1'b1;
          pending_value_next_s = pc_load_value;
        end else begin
          pending_valid_next_s = pending_valid_r;
          pending_value_next_s = pending_value_r;
        end
        state_next_s = WAIT;
      end
      WAIT: begin
        instruction_next_s   = imem_read_data;
        instr_addr_next_s    = pc_r;
        pending_valid_next_s = 1'b0;
        pending_value_next_s = {ADDR_WIDTH{1'b0}};
        // A load arriving on the completing edge is the most recent one.
        if (pc_load) begin
          pc_next_s = pc_load_value;
        end else if (pending_valid_r) begin
          pc_next_s = pending_value_r;
        end else begin
          pc_next_s = pc_r + PC_ONE;
        end
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      pc_r            <= RESET_VECTOR;
      pending_valid_r <= 1'b0;
      pending_value_r <= {ADDR_WIDTH{1'b0}};
      instruction_r   <= {INSTR_WIDTH{1'b0}};
      instr_addr_r    <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r         <= state_next_s;
      pc_r            <= pc_next_s;
      pending_valid_r <= pending_valid_next_s;
      pending_value_r <= pending_value_next_s;
      instruction_r   <= instruction_next_s;
      instr_addr_r    <= instr_addr_next_s;
    end
  end

  // Status flags registered from the next state, so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_enable_r <= 1'b0;
      valid_r       <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      read_enable_r <= (state_next_s == ISSUE);
      valid_r       <= (state_next_s == DONE);
      busy_r        <= (state_next_s != IDLE);
    end
  end

  assign imem_read_enable    = read_enable_r;
  assign imem_address        = pc_r;
  assign instruction         = instruction_r;
  assign instruction_address = instr_addr_r;
  assign program_counter     = pc_r;
  assign instruction_valid   = valid_r;
  assign busy                = busy_r;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the multicycle computer: holds the program counter, drives the read side of `instruction_memory`, and latches the returned 27-bit word into the instruction register for the control unit and decoder. A fetch is started by a one-cycle request from the control unit, and completion is signalled by a one-cycle `instruction_valid` pulse. The block also accepts PC loads for branches and jumps, including loads that arrive while a fetch is in flight.

## Interface
- `ADDR_WIDTH`, 14: instruction address width; must match `instruction_memory`.
- `INSTR_WIDTH`, 27: instruction word width.
- `RESET_VECTOR`, 14'h2000: PC value after reset; the instruction region starts here.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_request`  in  1  start a fetch; sampled only in IDLE or DONE.
- `pc_load`  in  1  load `pc_load_value` into the PC (branch/jump).
- `pc_load_value`  in  ADDR_WIDTH  target address.
- `imem_read_data`  in  INSTR_WIDTH  `instruction_memory.read_data`.
- `imem_read_enable`  out  1  to `instruction_memory.read_enable`.
- `imem_address`  out  ADDR_WIDTH  to `instruction_memory.address`.
- `instruction`  out  INSTR_WIDTH  instruction register.
- `instruction_address`  out  ADDR_WIDTH  address the current `instruction` was fetched from.
- `program_counter`  out  ADDR_WIDTH  next address to fetch.
- `instruction_valid`  out  1  one-cycle pulse when `instruction` is updated.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Fetch never writes memory. `instruction_memory.write_enable` is tied 0 at the top level.
- States:
  - **IDLE**: waiting for a request.
  - **ISSUE**: `imem_read_enable`=1 and `imem_address`=PC.
  - **WAIT**: memory output settles and `imem_read_data` is valid.
  - **DONE**: `instruction_valid`=1.
- Transitions:
  - IDLE→ISSUE on `fetch_request`.
  - ISSUE→WAIT unconditionally.
  - WAIT→DONE unconditionally.
  - DONE→ISSUE if `fetch_request` is high (back-to-back fetch); otherwise DONE→IDLE.
- On the WAIT→DONE edge, all of the following happen:
  - `instruction` ← `imem_read_data`.
  - `instruction_address` ← PC.
  - PC ← PC+1, modulo 2^ADDR_WIDTH, so 14'h3FFF wraps to 14'h0000.
- `pc_load` in IDLE or DONE: PC ← `pc_load_value` on that edge. If `fetch_request` is high in the same cycle, the fetch is issued at the loaded value.
- `pc_load` in ISSUE or WAIT:
  - The value is stored in a pending register and the in-flight fetch completes normally.
  - At the WAIT→DONE edge, PC ← pending value instead of PC+1, and the pending register clears.
  - Multiple loads during one fetch: the last one wins.
- `fetch_request` in ISSUE or WAIT is ignored; it is neither queued nor an error.
- `imem_address` equals PC in every state. It is stable throughout ISSUE.

## Timing
- Reset values, applied asynchronously:
  - State IDLE; PC = RESET_VECTOR.
  - `instruction`=0, `instruction_address`=0.
  - `instruction_valid`=0, `imem_read_enable`=0, `busy`=0.
  - Pending load cleared.
- Reset asserted mid-fetch: the fetch is abandoned, `imem_read_enable` drops immediately, and no `instruction_valid` is produced.
- Memory contract: `instruction_memory` registers its read on the clk edge while `read_enable`=1. Data is valid from that edge onward.
- Latency, counting `fetch_request` sampled at edge 0:
  - ISSUE in cycle 0–1.
  - Memory read at edge 1.
  - Capture at edge 2.
  - `instruction_valid` high during cycle 2–3.
- Throughput: one instruction per 3 cycles with `fetch_request` held high.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- **Reset then single fetch**: reset, memory[0x2000]=27'h5A5A5A0, pulse `fetch_request`.
  - `imem_address`=0x2000 with `read_enable` for exactly 1 cycle.
  - `instruction`=27'h5A5A5A0 and `instruction_address`=0x2000 with a 1-cycle valid pulse 2 cycles after the request.
  - `program_counter`=0x2001.
- **Back-to-back fetch**: hold `fetch_request` high for 9 cycles over memory[0x2000..0x2002]=1,2,3.
  - Valid pulses exactly every 3 cycles carrying 1, 2, 3.
  - PC ends at 0x2003.
- **Load while idle, same cycle as a request**: `pc_load`=1 with value 0x2100 and `fetch_request`=1.
  - Read issued at 0x2100.
  - `instruction_address`=0x2100 and PC=0x2101.
- **Load mid-fetch**: during WAIT, `pc_load` with value 0x2200.
  - The current fetch returns the word at the old PC.
  - PC=0x2200 afterwards, not old PC+1.
  - The next fetch reads 0x2200.
- **Wrap**: load 0x3FFF, fetch.
  - `instruction_address`=0x3FFF and PC=0x0000.
- **Reset mid-fetch**: assert `reset` during ISSUE.
  - `imem_read_enable`=0 immediately.
  - No valid pulse.
  - PC=0x2000 and `busy`=0.
